cdu_lock_sequencer: RTL and testbench
=====================================

// Module: cdu_lock_sequencer
// PURPOSE
//  Per-channel coarse/fine lock sequencer for one CDU gimbal channel (inner gimbal first, instanced per axis).
//  Drives the mode controls consumed by the error_angle and coarse blocks: ATLC1H, ATLF1H, ATLF2H, ARSETB, ADEL0H.
//  Walks the channel from reset, through coarse slew, to fine-1 and fine-2 lock using the tolerance flags.
//  Falls back to coarse on loss of tolerance and restarts on a CDU zero command.
// PARAMETERS
//  RSET_LEN    4   FAZ2HI strobes ARSETB is held after reset or zero release (1..255)
//  COARSE_HOLD 8   consecutive in-tolerance strobes in COARSE before entering FINE1 (1..255)
//  FINE_HOLD   16  consecutive in-tolerance strobes in FINE1 before entering FINE2 (1..255)
//  DEL_LEN     2   strobes ADEL0H is held on each entry to FINE1 (0..255; 0 = never asserted)
// PORTS
//  CLOCKH   in   1  single system clock; all state changes on its rising edge
//  rst      in   1  synchronous active-high reset
//  FAZ2HI   in   1  phase-2 strobe, 1 clock wide; the only sequencing enable
//  ACDUZ    in   1  CDU zero command, level; overrides everything
//  ACTOLH   in   1  coarse error within tolerance (from coarse system)
//  AFTOLH   in   1  fine error within tolerance (from error_angle)
//  ARSETB   out  1  read-counter reset, high in RSET state
//  ATLC1H   out  1  coarse-loop enable, high in COARSE state
//  ATLF1H   out  1  fine-1 enable, high in FINE1 and FINE2
//  ATLF2H   out  1  fine-2 enable, high in FINE2
//  ADEL0H   out  1  zero-crossing delay inhibit, high during the first DEL_LEN strobes of FINE1
//  ALOCKH   out  1  channel locked, high in FINE2
//  AFALLH   out  1  one-clock pulse on each fallback to COARSE
//  AFALLC   out  8  fallback count, saturates at 255
//  ASTATE   out  2  state code: 0 RSET, 1 COARSE, 2 FINE1, 3 FINE2
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=RSET, hold counter=0, AFALLC=0, AFALLH=0; ARSETB=1; all other outputs 0.
//  rst has priority over every other input. A mid-operation reset behaves exactly like the initial reset.
//  Outputs other than AFALLH/AFALLC are a combinational decode of the registered state and counters.
//  They therefore change at the edge that ends the deciding FAZ2HI cycle. Latency is 0 cycles beyond that edge.
//  State and counters advance only at edges where FAZ2HI=1; otherwise everything holds. The one exception is ACDUZ.
//  ACDUZ=1 at any edge (strobe or not): state=RSET, hold counter=0, and the state stays RSET while ACDUZ=1. No fallback is counted.
//  RSET: each strobe with ACDUZ=0 increments the counter. At the strobe where counter==RSET_LEN-1 -> COARSE, counter=0.
//  COARSE: each strobe with ACTOLH=1 increments the counter; ACTOLH=0 clears it.
//          At the strobe where counter==COARSE_HOLD-1 and ACTOLH=1 -> FINE1, counter=0.
//  FINE1: the ADEL0H counter loads DEL_LEN on entry and decrements per strobe to 0. ADEL0H=1 while it is nonzero.
//         ACTOLH=0 at a strobe -> COARSE, fallback. This has priority over the fine count.
//         Otherwise AFTOLH=1 increments the hold counter and AFTOLH=0 clears it.
//         At the strobe where counter==FINE_HOLD-1 and AFTOLH=1 -> FINE2.
//  FINE2: ACTOLH=0 at a strobe -> COARSE, fallback. Else AFTOLH=0 -> FINE1, no fallback; ADEL0H is re-armed.
//  Fallback: AFALLH=1 for the single clock after the transition edge. AFALLC increments, saturating at 255 (no wrap).
//  Counters are 8 bits. Hold counters saturate and never wrap. A strobe coinciding with ACDUZ=1 is consumed by ACDUZ.
// TESTING
//  rst=1 for 2 clocks, then strobes every 4 clocks with ACDUZ=0 -> ARSETB=1 for exactly 4 strobes, then ATLC1H=1, ASTATE=1.
//  COARSE with ACTOLH=1 for 7 strobes, 0 for 1 strobe, then 1 for 8 strobes -> FINE1 entered on the 16th strobe only; ADEL0H=1 for the next 2 strobes.
//  FINE1 with AFTOLH=1 and ACTOLH=1 for 16 strobes -> ALOCKH=ATLF2H=ATLF1H=1, ASTATE=3; AFALLC=0.
//  In FINE2, drop AFTOLH for 1 strobe -> ASTATE=2, ATLF2H=0, ADEL0H=1, AFALLH never pulses.
//  In FINE2, drop ACTOLH -> ASTATE=1, AFALLH=1 for 1 clock, AFALLC=1. Force 260 fallbacks -> AFALLC=255.
//  Assert ACDUZ for 1 non-strobe clock while in FINE2 -> ASTATE=0 and ARSETB=1 next edge. Assert rst mid-FINE1 -> all outputs at reset values, AFALLC=0.

Source files
------------

// File: rtl/cdu_lock_sequencer.sv
// Coarse/fine lock sequencer for one CDU gimbal channel.
// Walks RSET -> COARSE -> FINE1 -> FINE2 on FAZ2HI strobes using the tolerance flags.
//
// Ports:
//   CLOCKH  in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   FAZ2HI  in   phase-2 strobe, the only sequencing enable
//   ACDUZ   in   CDU zero command (level), overrides sequencing
//   ACTOLH  in   coarse error within tolerance
//   AFTOLH  in   fine error within tolerance
//   ARSETB  out  read-counter reset (RSET)
//   ATLC1H  out  coarse-loop enable (COARSE)
//   ATLF1H  out  fine-1 enable (FINE1, FINE2)
//   ATLF2H  out  fine-2 enable (FINE2)
//   ADEL0H  out  zero-crossing delay inhibit, first DEL_LEN strobes of FINE1
//   ALOCKH  out  channel locked (FINE2)
//   AFALLH  out  one-clock pulse after each fallback to COARSE
//   AFALLC  out  saturating fallback count
//   ASTATE  out  state code 0..3
module cdu_lock_sequencer #(
    parameter int RSET_LEN    = 4,
    parameter int COARSE_HOLD = 8,
    parameter int FINE_HOLD   = 16,
    parameter int DEL_LEN     = 2
) (
    input  logic       CLOCKH,
    input  logic       rst,
    input  logic       FAZ2HI,
    input  logic       ACDUZ,
    input  logic       ACTOLH,
    input  logic       AFTOLH,
    output logic       ARSETB,
    output logic       ATLC1H,
    output logic       ATLF1H,
    output logic       ATLF2H,
    output logic       ADEL0H,
    output logic       ALOCKH,
    output logic       AFALLH,
    output logic [7:0] AFALLC,
    output logic [1:0] ASTATE
);

    typedef enum logic [1:0] {
        S_RSET   = 2'd0,
        S_COARSE = 2'd1,
        S_FINE1  = 2'd2,
        S_FINE2  = 2'd3
    } state_e;

    localparam logic [7:0] RSET_LAST   = 8'(RSET_LEN - 1);
    localparam logic [7:0] COARSE_LAST = 8'(COARSE_HOLD - 1);
    localparam logic [7:0] FINE_LAST   = 8'(FINE_HOLD - 1);
    localparam logic [7:0] DEL_INIT    = 8'(DEL_LEN);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] del_q, del_d;
    logic [7:0] fallc_q, fallc_d;
    logic       fallh_q, fallh_d;
    logic [7:0] cnt_inc;

    // Hold counter never wraps.
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_ff @(posedge CLOCKH) begin
        if (rst) begin
            state_q <= S_RSET;
            cnt_q   <= 8'd0;
            del_q   <= 8'd0;
            fallc_q <= 8'd0;
            fallh_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            del_q   <= del_d;
            fallc_q <= fallc_d;
            fallh_q <= fallh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        del_d   = del_q;
        fallc_d = fallc_q;
        fallh_d = 1'b0;

        if (ACDUZ) begin
            // Zero command wins at every edge and swallows any strobe.
            state_d = S_RSET;
            cnt_d   = 8'd0;
            del_d   = 8'd0;
        end else if (FAZ2HI) begin
            case (state_q)
                S_RSET: begin
                    if (cnt_q == RSET_LAST) begin
                        state_d = S_COARSE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_COARSE: begin
                    if (!ACTOLH) begin
                        cnt_d = 8'd0;
                    end else if (cnt_q == COARSE_LAST) begin
                        state_d = S_FINE1;
                        cnt_d   = 8'd0;
                        del_d   = DEL_INIT;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_FINE1: begin
                    if (del_q != 8'd0) begin
                        del_d = del_q - 8'd1;
                    end
                    // Loss of coarse tolerance beats the fine count.
                    if (!ACTOLH) begin
                        state_d = S_COARSE;
                        cnt_d   = 8'd0;
                        fallh_d = 1'b1;
                        if (fallc_q != 8'hFF) begin
                            fallc_d = fallc_q + 8'd1;
                        end
                    end else if (!AFTOLH) begin
                        cnt_d = 8'd0;
                    end else if (cnt_q == FINE_LAST) begin
                        state_d = S_FINE2;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_FINE2: begin
                    if (!ACTOLH) begin
                        state_d = S_COARSE;
                        cnt_d   = 8'd0;
                        fallh_d = 1'b1;
                        if (fallc_q != 8'hFF) begin
                            fallc_d = fallc_q + 8'd1;
                        end
                    end else if (!AFTOLH) begin
                        // Drop back to fine-1 only; inhibit is re-armed.
                        state_d = S_FINE1;
                        cnt_d   = 8'd0;
                        del_d   = DEL_INIT;
                    end
                end
                default: begin
                    state_d = S_RSET;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    assign ARSETB = (state_q == S_RSET);
    assign ATLC1H = (state_q == S_COARSE);
    assign ATLF1H = (state_q == S_FINE1) || (state_q == S_FINE2);
    assign ATLF2H = (state_q == S_FINE2);
    assign ALOCKH = (state_q == S_FINE2);
    assign ADEL0H = (state_q == S_FINE1) && (del_q != 8'd0);
    assign AFALLH = fallh_q;
    assign AFALLC = fallc_q;
    assign ASTATE = state_q;

endmodule

// File: tb/tb_cdu_lock_sequencer.sv
// Directed bench for cdu_lock_sequencer.
// Scenario tasks run in order from one initial block.
module tb_cdu_lock_sequencer;

    logic       CLOCKH = 1'b0;
    logic       rst    = 1'b1;
    logic       FAZ2HI = 1'b0;
    logic       ACDUZ  = 1'b0;
    logic       ACTOLH = 1'b0;
    logic       AFTOLH = 1'b0;
    logic       ARSETB, ATLC1H, ATLF1H, ATLF2H, ADEL0H, ALOCKH, AFALLH;
    logic [7:0] AFALLC;
    logic [1:0] ASTATE;
    logic [6:0] outs;

    int n_tests = 0;
    int n_fail  = 0;

    cdu_lock_sequencer dut (
        .CLOCKH(CLOCKH), .rst(rst), .FAZ2HI(FAZ2HI), .ACDUZ(ACDUZ),
        .ACTOLH(ACTOLH), .AFTOLH(AFTOLH), .ARSETB(ARSETB),
        .ATLC1H(ATLC1H), .ATLF1H(ATLF1H), .ATLF2H(ATLF2H),
        .ADEL0H(ADEL0H), .ALOCKH(ALOCKH), .AFALLH(AFALLH),
        .AFALLC(AFALLC), .ASTATE(ASTATE)
    );

    always #5 CLOCKH = ~CLOCKH;

    // {ARSETB, ATLC1H, ATLF1H, ATLF2H, ADEL0H, ALOCKH, AFALLH}
    assign outs = {ARSETB, ATLC1H, ATLF1H, ATLF2H, ADEL0H, ALOCKH, AFALLH};

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCKH);
            #1;
        end
    endtask

    // One strobe edge; returns #1 after it so AFALLH can be seen.
    task automatic strobe_edge();
        FAZ2HI = 1'b1;
        tick(1);
        FAZ2HI = 1'b0;
    endtask

    task automatic strobe(input int gap);
        strobe_edge();
        tick(gap);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        n_tests++;
        if (outs !== 7'b1000000 || ASTATE !== 2'd0 || AFALLC !== 8'd0) begin
            n_fail++;
            $display("FAIL reset: outs=%b st=%0d fc=%0d want 1000000/0/0", outs, ASTATE, AFALLC);
        end
        rst = 1'b0;
    endtask

    task automatic test_rset();
        for (int i = 1; i <= 3; i++) begin
            strobe(3);
            n_tests++;
            if (ASTATE !== 2'd0 || ARSETB !== 1'b1) begin
                n_fail++;
                $display("FAIL rset_hold%0d: st=%0d rsetb=%b want 0/1", i, ASTATE, ARSETB);
            end
        end
        strobe(3);
        n_tests++;
        if (outs !== 7'b0100000 || ASTATE !== 2'd1) begin
            n_fail++;
            $display("FAIL rset_exit: outs=%b st=%0d want 0100000/1", outs, ASTATE);
        end
    endtask

    task automatic test_coarse();
        ACTOLH = 1'b1;
        repeat (7) strobe(3);
        ACTOLH = 1'b0;
        strobe(3);
        ACTOLH = 1'b1;
        repeat (7) strobe(3);
        n_tests++;
        if (ASTATE !== 2'd1) begin
            n_fail++;
            $display("FAIL coarse_15: st=%0d want 1", ASTATE);
        end
        strobe(3);
        n_tests++;
        if (outs !== 7'b0010100 || ASTATE !== 2'd2) begin
            n_fail++;
            $display("FAIL coarse_16: outs=%b st=%0d want 0010100/2", outs, ASTATE);
        end
    endtask

    task automatic test_fine();
        AFTOLH = 1'b1;
        strobe(3);
        n_tests++;
        if (ADEL0H !== 1'b1) begin
            n_fail++;
            $display("FAIL del_1: adel0h=%b want 1", ADEL0H);
        end
        strobe(3);
        n_tests++;
        if (ADEL0H !== 1'b0) begin
            n_fail++;
            $display("FAIL del_2: adel0h=%b want 0", ADEL0H);
        end
        repeat (13) strobe(3);
        n_tests++;
        if (ASTATE !== 2'd2) begin
            n_fail++;
            $display("FAIL fine1_15: st=%0d want 2", ASTATE);
        end
        strobe(3);
        n_tests++;
        if (outs !== 7'b0011010 || ASTATE !== 2'd3 || AFALLC !== 8'd0) begin
            n_fail++;
            $display("FAIL fine2_entry: outs=%b st=%0d fc=%0d want 0011010/3/0", outs, ASTATE, AFALLC);
        end
    endtask

    task automatic test_fine_drop();
        AFTOLH = 1'b0;
        strobe_edge();
        n_tests++;
        if (outs !== 7'b0010100 || ASTATE !== 2'd2) begin
            n_fail++;
            $display("FAIL fine_drop: outs=%b st=%0d want 0010100/2", outs, ASTATE);
        end
        tick(3);
        AFTOLH = 1'b1;
        repeat (16) strobe(3);
        n_tests++;
        if (ASTATE !== 2'd3 || AFALLC !== 8'd0) begin
            n_fail++;
            $display("FAIL fine_relock: st=%0d fc=%0d want 3/0", ASTATE, AFALLC);
        end
    endtask

    task automatic test_fallback();
        ACTOLH = 1'b0;
        strobe_edge();
        n_tests++;
        if (outs !== 7'b0100001 || ASTATE !== 2'd1 || AFALLC !== 8'd1) begin
            n_fail++;
            $display("FAIL fallback: outs=%b st=%0d fc=%0d want 0100001/1/1", outs, ASTATE, AFALLC);
        end
        tick(1);
        n_tests++;
        if (AFALLH !== 1'b0) begin
            n_fail++;
            $display("FAIL fallback_pulse: afallh=%b want 0", AFALLH);
        end
        tick(2);
    endtask

    task automatic test_saturation();
        for (int i = 2; i <= 260; i++) begin
            ACTOLH = 1'b1;
            repeat (8) strobe(1);
            ACTOLH = 1'b0;
            strobe(1);
            if (i == 200) begin
                n_tests++;
                if (AFALLC !== 8'd200) begin
                    n_fail++;
                    $display("FAIL fallc_200: fc=%0d want 200", AFALLC);
                end
            end
        end
        n_tests++;
        if (AFALLC !== 8'd255 || ASTATE !== 2'd1) begin
            n_fail++;
            $display("FAIL fallc_sat: fc=%0d st=%0d want 255/1", AFALLC, ASTATE);
        end
    endtask

    task automatic test_zero();
        ACTOLH = 1'b1;
        AFTOLH = 1'b1;
        repeat (24) strobe(1);
        n_tests++;
        if (ASTATE !== 2'd3) begin
            n_fail++;
            $display("FAIL zero_pre: st=%0d want 3", ASTATE);
        end
        ACDUZ = 1'b1;
        tick(1);
        n_tests++;
        if (outs !== 7'b1000000 || ASTATE !== 2'd0 || AFALLC !== 8'd255) begin
            n_fail++;
            $display("FAIL zero_enter: outs=%b st=%0d fc=%0d want 1000000/0/255", outs, ASTATE, AFALLC);
        end
        repeat (4) strobe(1);
        n_tests++;
        if (ASTATE !== 2'd0) begin
            n_fail++;
            $display("FAIL zero_hold: st=%0d want 0", ASTATE);
        end
        ACDUZ = 1'b0;
        repeat (3) strobe(1);
        n_tests++;
        if (ASTATE !== 2'd0) begin
            n_fail++;
            $display("FAIL zero_rset3: st=%0d want 0", ASTATE);
        end
        strobe(1);
        n_tests++;
        if (ASTATE !== 2'd1 || AFALLH !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_exit: st=%0d afallh=%b want 1/0", ASTATE, AFALLH);
        end
    endtask

    task automatic test_mid_reset();
        ACTOLH = 1'b1;
        AFTOLH = 1'b1;
        repeat (9) strobe(1);
        n_tests++;
        if (ASTATE !== 2'd2) begin
            n_fail++;
            $display("FAIL mid_pre: st=%0d want 2", ASTATE);
        end
        rst = 1'b1;
        FAZ2HI = 1'b1;
        tick(1);
        FAZ2HI = 1'b0;
        n_tests++;
        if (outs !== 7'b1000000 || ASTATE !== 2'd0 || AFALLC !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset: outs=%b st=%0d fc=%0d want 1000000/0/0", outs, ASTATE, AFALLC);
        end
        rst = 1'b0;
        repeat (3) strobe(1);
        n_tests++;
        if (ASTATE !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_rset3: st=%0d want 0", ASTATE);
        end
        strobe(1);
        n_tests++;
        if (ASTATE !== 2'd1) begin
            n_fail++;
            $display("FAIL mid_rset4: st=%0d want 1", ASTATE);
        end
    endtask

    initial begin
        test_reset();
        test_rset();
        test_coarse();
        test_fine();
        test_fine_drop();
        test_fallback();
        test_saturation();
        test_zero();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
